// File: rtl/bitcount_scheduler.sv
// Round-robin scheduler that time-shares one ones-counting datapath among N_REQ requesters.
// The winner's operand is steered onto data_A and the datapath is stepped until A runs out of ones.
module bitcount_scheduler #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [CNT_W-1:0]        resp_result,
    output logic [IDX_W-1:0]        resp_id,
    output logic                    busy,
    output logic [DATA_W-1:0]       data_A,
    output logic                    load_A,
    output logic                    result_zero,
    output logic                    rightshift_A,
    output logic                    incr_result,
    input  logic                    z,
    input  logic                    a0,
    input  logic [CNT_W-1:0]        result
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                       state, state_next;
    logic [IDX_W-1:0]             grant_id, grant_next;
    logic [IDX_W-1:0]             rr_ptr, rr_next;
    logic [N_REQ-1:0][DATA_W-1:0] opnd;
    logic [IDX_W-1:0]             win_id, cand, sel_id;
    logic                         win_found;
    int                           slot;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_opnd
            assign opnd[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan downward from the farthest slot so the nearest requester at or after rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr;
        cand      = '0;
        slot      = 0;
        for (int j = N_REQ-1; j >= 0; j--) begin
            slot = int'(rr_ptr) + j;
            if (slot >= N_REQ) slot = slot - N_REQ;
            cand = IDX_W'(slot);
            if (req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign sel_id = (state == IDLE) ? win_id : grant_id;
    assign data_A = opnd[sel_id];

    always_comb begin
        state_next   = state;
        grant_next   = grant_id;
        rr_next      = rr_ptr;
        load_A       = 1'b0;
        result_zero  = 1'b0;
        rightshift_A = 1'b0;
        incr_result  = 1'b0;
        ack          = '0;
        resp_id      = '0;
        resp_result  = '0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    load_A      = 1'b1;
                    result_zero = 1'b1;
                    grant_next  = win_id;
                    state_next  = COUNT;
                end
            end
            COUNT: begin
                busy = 1'b1;
                if (z) begin
                    state_next = DONE;
                end else begin
                    rightshift_A = 1'b1;
                    incr_result  = a0;
                end
            end
            DONE: begin
                busy          = 1'b1;
                ack[grant_id] = 1'b1;
                resp_id       = grant_id;
                resp_result   = result;
                rr_next       = (grant_id == IDX_W'(N_REQ-1)) ? '0 : grant_id + IDX_W'(1);
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Quiet everything during reset so an aborted job can never produce an ack or strobe.
        if (reset) begin
            load_A       = 1'b0;
            result_zero  = 1'b0;
            rightshift_A = 1'b0;
            incr_result  = 1'b0;
            ack          = '0;
            resp_id      = '0;
            resp_result  = '0;
            busy         = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            rr_ptr   <= rr_next;
        end
    end

endmodule

// File: tb/tb_bitcount_scheduler.sv
// Bench for bitcount_scheduler: a behavioural datapath plus a latency/round-robin reference model.
module tb_bitcount_scheduler;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 2;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [CNT_W-1:0]        resp_result;
    logic [IDX_W-1:0]        resp_id;
    logic                    busy;
    logic [DATA_W-1:0]       data_A;
    logic                    load_A, result_zero, rightshift_A, incr_result;
    logic                    z, a0;
    logic [CNT_W-1:0]        result;

    logic [DATA_W-1:0] opnd [N_REQ];

    int n_err = 0;
    int n_chk = 0;

    bitcount_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .resp_result(resp_result), .resp_id(resp_id), .busy(busy),
        .data_A(data_A), .load_A(load_A), .result_zero(result_zero),
        .rightshift_A(rightshift_A), .incr_result(incr_result),
        .z(z), .a0(a0), .result(result)
    );

    always #5 clock = ~clock;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = opnd[i];
    end

    // Datapath: shift register + counter, deliberately not touched by reset.
    logic [DATA_W-1:0] dp_a   = '0;
    logic [CNT_W-1:0]  dp_cnt = '0;
    always @(posedge clock) begin
        if (load_A) dp_a <= data_A;
        else if (rightshift_A) dp_a <= dp_a >> 1;
        if (result_zero) dp_cnt <= '0;
        else if (incr_result) dp_cnt <= dp_cnt + 1'b1;
    end
    assign z      = (dp_a == '0);
    assign a0     = dp_a[0];
    assign result = dp_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int popcnt(input logic [DATA_W-1:0] d);
        int c = 0;
        for (int i = 0; i < DATA_W; i++) c += int'(d[i]);
        return c;
    endfunction

    function automatic int hibit(input logic [DATA_W-1:0] d);
        int k = 0;
        for (int i = 0; i < DATA_W; i++) if (d[i]) k = i + 1;
        return k;
    endfunction

    // Reference model: a grant starts a job lasting 2+k cycles to its ack; pointer moves past the winner.
    int               cyc = 0;
    logic             m_busy = 1'b0;
    int               m_ptr = 0, m_g = 0, m_k = 0, m_ack = 0, m_win = 0;
    logic [DATA_W-1:0] m_d = '0;
    logic [N_REQ-1:0] ack_last = '0;
    int               ack_log [$];

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            ack_last = ack;
            if (reset) begin
                chk("rst_ack", ack, 0);
                chk("rst_busy", busy, 0);
                chk("rst_strobes", {load_A, result_zero, rightshift_A, incr_result}, 0);
                chk("rst_resp", {resp_id, resp_result}, 0);
                m_busy = 1'b0;
                m_ptr  = 0;
            end else if (!m_busy) begin
                chk("idle_busy", busy, 0);
                chk("idle_ack", ack, 0);
                chk("idle_shift", {rightshift_A, incr_result}, 0);
                if (req != '0) begin
                    m_win = -1;
                    for (int j = 0; j < N_REQ; j++)
                        if (m_win < 0 && req[(m_ptr + j) % N_REQ]) m_win = (m_ptr + j) % N_REQ;
                    chk("grant_load", {load_A, result_zero}, 2'b11);
                    chk("grant_data_A", data_A, opnd[m_win]);
                    m_d    = opnd[m_win];
                    m_k    = hibit(m_d);
                    m_g    = cyc;
                    m_ack  = cyc + 2 + m_k;
                    m_busy = 1'b1;
                end else begin
                    chk("idle_load", {load_A, result_zero}, 0);
                end
            end else begin
                chk("busy", busy, 1);
                chk("busy_load", {load_A, result_zero}, 0);
                if (cyc == m_ack) begin
                    chk("ack", ack, 1 << m_win);
                    chk("resp_id", resp_id, m_win);
                    chk("resp_result", resp_result, popcnt(m_d));
                    chk("done_shift", {rightshift_A, incr_result}, 0);
                    ack_log.push_back(m_win);
                    m_busy = 1'b0;
                    m_ptr  = (m_win + 1) % N_REQ;
                end else begin
                    chk("early_ack", ack, 0);
                    chk("shift", rightshift_A, (cyc - m_g) <= m_k);
                    chk("incr", incr_result, ((cyc - m_g) <= m_k) ? m_d[cyc - m_g - 1] : 1'b0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic job(input int id, input logic [DATA_W-1:0] d);
        int t = 0;
        opnd[id] = d;
        req[id]  = 1'b1;
        do begin
            tick();
            t++;
        end while (!ack_last[id] && t < 40);
        chk("job_timeout", ack_last[id], 1);
        req[id] = 1'b0;
        tick();
    endtask

    task automatic drain_acks(input int budget);
        int t = 0;
        while (req != '0 && t < budget) begin
            tick();
            t++;
            for (int i = 0; i < N_REQ; i++) if (req[i] && ack_last[i]) req[i] = 1'b0;
        end
        chk("drain_timeout", req, 0);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < N_REQ; i++) opnd[i] = '0;
        tick();
        do_reset();

        job(0, 8'h00);
        job(1, 8'hFF);
        job(2, 8'hAA);
        job(2, 8'h01);

        // All four at once from a fresh pointer.
        do_reset();
        ack_log.delete();
        opnd[0] = 8'h03; opnd[1] = 8'h80; opnd[2] = 8'h0F; opnd[3] = 8'h00;
        req = 4'hF;
        drain_acks(100);
        chk("order_len", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("order", ack_log[i], i);
        tick();

        // Two requesters held continuously must alternate; pointer has wrapped to 0.
        ack_log.delete();
        opnd[0] = 8'h01; opnd[3] = 8'h03;
        req[0] = 1'b1; req[3] = 1'b1;
        repeat (40) tick();
        req = '0;
        repeat (12) tick();
        chk("alt_len_ok", ack_log.size() >= 6, 1);
        for (int i = 0; i < ack_log.size(); i++) chk("alternate", ack_log[i], (i % 2) ? 3 : 0);

        // Reset in the 4th COUNT cycle of an 0xFF job.
        do_reset();
        ack_log.delete();
        opnd[2] = 8'hFF;
        req[2]  = 1'b1;
        repeat (4) tick();
        reset  = 1'b1;
        req[2] = 1'b0;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("aborted_no_ack", ack_log.size(), 0);
        job(1, 8'h07);
        chk("after_abort_id", (ack_log.size() == 1) ? ack_log[0] : -1, 1);

        // Random traffic with occasional reset.
        for (int c = 0; c < 1500; c++) begin
            tick();
            reset = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && ack_last[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    opnd[i] = DATA_W'($urandom_range(0, 255) >> $urandom_range(0, 7));
                    req[i]  = 1'b1;
                end
            end
        end
        reset = 1'b0;
        drain_acks(200);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
